// File: rtl/frame_buffer_dp.sv
// Dual-port single-clock frame buffer: camera-side write port (explicit or auto-increment),
// display-side registered read port, range protection, collision bypass and a whole-memory clear engine.
module frame_buffer_dp #(
    parameter int              DW        = 16,
    parameter int              AW        = 17,
    parameter int              DEPTH     = 76800,
    parameter logic [DW-1:0]   CLEAR_VAL = '0,
    parameter bit              BYPASS    = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr_in,
    input  logic [DW-1:0] data_in,
    input  logic          regwrite,
    input  logic          wr_auto,
    input  logic [AW-1:0] addr_out,
    input  logic          regread,
    input  logic          clear,
    output logic [DW-1:0] data_out,
    output logic          rd_valid,
    output logic [AW-1:0] wr_ptr,
    output logic          frame_done,
    output logic          busy,
    output logic          dbg_state
);

    // Handshake: strobes are single-cycle qualifiers sampled at the rising edge; there is no
    // backpressure. A read strobe at edge N yields data_out/rd_valid valid after edge N.

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    logic [DW-1:0] r_mem [0:DEPTH-1];

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_clr_addr;
    logic [AW-1:0] r_wr_ptr;
    logic [DW-1:0] r_data_out;
    logic          r_rd_valid;
    logic          r_frame_done;

    logic [AW-1:0] w_wr_addr;
    logic          w_user_wr;
    logic          w_auto_wr;
    logic          w_clr_last;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_data;
    logic          w_rd_in_range;
    logic          w_collide;

    assign w_wr_addr  = wr_auto ? r_wr_ptr : addr_in;
    assign w_user_wr  = (r_state == S_IDLE) && regwrite && ({1'b0, w_wr_addr} < DEPTH_W);
    assign w_auto_wr  = w_user_wr && wr_auto;
    assign w_clr_last = (r_state == S_CLEAR) && (r_clr_addr == LAST);

    // Clear engine owns the single write port while active; user writes are dropped.
    assign w_mem_we   = !rst && (w_user_wr || (r_state == S_CLEAR));
    assign w_mem_addr = (r_state == S_CLEAR) ? r_clr_addr : w_wr_addr;
    assign w_mem_data = (r_state == S_CLEAR) ? CLEAR_VAL : data_in;

    assign w_rd_in_range = ({1'b0, addr_out} < DEPTH_W);
    assign w_collide     = w_mem_we && (w_mem_addr == addr_out);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (clear) w_state_next = S_CLEAR;
            S_CLEAR: if (w_clr_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= regread;
            if (regread) begin
                if (!w_rd_in_range)          r_data_out <= '0;
                else if (BYPASS && w_collide) r_data_out <= w_mem_data;
                else                          r_data_out <= r_mem[addr_out];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_addr <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_addr <= w_clr_last ? '0 : r_clr_addr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_auto_wr && (r_wr_ptr == LAST);
            if (w_clr_last)     r_wr_ptr <= '0;
            else if (w_auto_wr) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
        end
    end

    assign data_out   = r_data_out;
    assign rd_valid   = r_rd_valid;
    assign wr_ptr     = r_wr_ptr;
    assign frame_done = r_frame_done;
    assign busy       = (r_state == S_CLEAR);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_frame_buffer_dp.sv
// Directed bench for frame_buffer_dp: a BYPASS=1 and a BYPASS=0 instance share all inputs,
// shrunk to a 200-word memory so full-frame and full-clear sequences stay short.
module tb_frame_buffer_dp;

    localparam int            DW    = 16;
    localparam int            AW    = 8;
    localparam int            DEPTH = 200;
    localparam logic [DW-1:0] CVAL  = 16'hFFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          regwrite;
    logic          wr_auto;
    logic [AW-1:0] addr_out;
    logic          regread;
    logic          clear;

    logic [DW-1:0] data_out_b, data_out_n;
    logic          rd_valid_b, rd_valid_n;
    logic [AW-1:0] wr_ptr_b, wr_ptr_n;
    logic          frame_done_b, frame_done_n;
    logic          busy_b, busy_n;
    logic          dbg_state_b, dbg_state_n;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    frame_buffer_dp #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .CLEAR_VAL(CVAL), .BYPASS(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in), .regwrite(regwrite),
        .wr_auto(wr_auto), .addr_out(addr_out), .regread(regread), .clear(clear),
        .data_out(data_out_b), .rd_valid(rd_valid_b), .wr_ptr(wr_ptr_b),
        .frame_done(frame_done_b), .busy(busy_b), .dbg_state(dbg_state_b)
    );

    frame_buffer_dp #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .CLEAR_VAL(CVAL), .BYPASS(1'b0)) u_dut_n (
        .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in), .regwrite(regwrite),
        .wr_auto(wr_auto), .addr_out(addr_out), .regread(regread), .clear(clear),
        .data_out(data_out_n), .rd_valid(rd_valid_n), .wr_ptr(wr_ptr_n),
        .frame_done(frame_done_n), .busy(busy_n), .dbg_state(dbg_state_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        regwrite = 1'b0; wr_auto = 1'b0; regread = 1'b0; clear = 1'b0;
        addr_in = '0; data_in = '0; addr_out = '0;
    endtask

    task automatic read_both(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        idle_inputs();
        regread = 1'b1; addr_out = a;
        step();
        chk({tag, "_b"}, data_out_b, exp);
        chk({tag, "_n"}, data_out_n, exp);
        chk({tag, "_vld"}, rd_valid_b, 1);
        regread = 1'b0;
    endtask

    initial begin
        idle_inputs();
        // T1: reset
        rst = 1'b1;
        step(); step();
        chk("rst_data", data_out_b, 0);
        chk("rst_valid", rd_valid_b, 0);
        chk("rst_wrptr", wr_ptr_b, 0);
        chk("rst_busy", busy_b, 0);
        chk("rst_fdone", frame_done_b, 0);
        chk("rst_busy_n", busy_n, 0);
        rst = 1'b0;

        // T2: explicit write then read, valid lasts one cycle
        regwrite = 1'b1; addr_in = 8'd0; data_in = 16'd234;
        step();
        read_both(8'd0, 16'd234, "t2_read");
        step();
        chk("t2_valid_drop", rd_valid_b, 0);
        chk("t2_data_hold", data_out_b, 234);

        // T3: collision on same address, same edge
        regwrite = 1'b1; addr_in = 8'd100; data_in = 16'h1234;
        step();
        regwrite = 1'b1; addr_in = 8'd100; data_in = 16'h55AA;
        regread = 1'b1; addr_out = 8'd100;
        step();
        chk("t3_coll_bypass", data_out_b, 16'h55AA);
        chk("t3_coll_old", data_out_n, 16'h1234);
        read_both(8'd100, 16'h55AA, "t3_after");
        chk("t3_wrptr_fixed", wr_ptr_b, 0);

        // T4: full auto frame, data = index
        idle_inputs();
        wr_auto = 1'b1; regwrite = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            data_in = 16'(i);
            addr_in = 8'd7;
            step();
            chk("t4_fdone", frame_done_b, (i == DEPTH - 1) ? 1 : 0);
            chk("t4_wrptr", wr_ptr_b, (i + 1) % DEPTH);
        end
        idle_inputs();
        step();
        chk("t4_fdone_single", frame_done_b, 0);
        read_both(8'd199, 16'd199, "t4_last");
        read_both(8'd100, 16'd100, "t4_mid");
        read_both(8'd7, 16'd7, "t4_no_explicit");

        // Out-of-range read and write
        read_both(8'd200, 16'd0, "t6_rd_oor");
        read_both(8'd255, 16'd0, "t6_rd_oor_max");
        idle_inputs();
        regwrite = 1'b1; addr_in = 8'd200; data_in = 16'hBEEF;
        step();
        chk("t6_wr_oor_ptr", wr_ptr_b, 0);
        chk("t6_wr_oor_fdone", frame_done_b, 0);
        chk("t6_wr_oor_busy", busy_b, 0);
        read_both(8'd199, 16'd199, "t6_neighbour");

        // T5: full clear; ignored writes; collision with the clear write
        idle_inputs();
        clear = 1'b1;
        step();
        chk("t5_busy_start", busy_b, 1);
        for (int c = 1; c <= DEPTH; c++) begin
            idle_inputs();
            if (c == 20) begin regwrite = 1'b1; addr_in = 8'd3; data_in = 16'h1111; end
            if (c == 30) begin regwrite = 1'b1; wr_auto = 1'b1; data_in = 16'h2222; end
            if (c == 40) clear = 1'b1;
            if (c == 50) begin regread = 1'b1; addr_out = 8'd49; end
            step();
            chk("t5_busy", busy_b, (c < DEPTH) ? 1 : 0);
            if (c == 50) begin
                chk("t5_coll_bypass", data_out_b, CVAL);
                chk("t5_coll_old", data_out_n, 16'd49);
            end
        end
        idle_inputs();
        step();
        chk("t5_idle_after", busy_b, 0);
        chk("t5_wrptr", wr_ptr_b, 0);
        read_both(8'd5, CVAL, "t5_read5");
        read_both(8'd3, CVAL, "t5_write_ignored");
        read_both(8'd0, CVAL, "t5_first");
        read_both(8'd199, CVAL, "t5_last");

        // T6: clear + write in same cycle, then reset mid-clear
        idle_inputs();
        regwrite = 1'b1; addr_in = 8'd0; data_in = 16'h0AAA;
        step();
        regwrite = 1'b1; addr_in = 8'd190; data_in = 16'h0BBB;
        step();
        regwrite = 1'b1; addr_in = 8'd150; data_in = 16'hABCD; clear = 1'b1;
        step();
        chk("t6_busy_clear", busy_b, 1);
        idle_inputs();
        step(); step(); step();
        rst = 1'b1;
        step();
        chk("t6_abort_busy", busy_b, 0);
        chk("t6_abort_busy_n", busy_n, 0);
        rst = 1'b0;
        step();
        chk("t6_stay_idle", busy_b, 0);
        read_both(8'd0, CVAL, "t6_addr0_cleared");
        read_both(8'd190, 16'h0BBB, "t6_tail_kept");
        read_both(8'd150, 16'hABCD, "t6_same_cycle_wr");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
